// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-mapped I/O target for the 3-stage core. Decodes stage-2 load/store
//   requests inside the MMIO window (addr[31:28] == MMIO_BASE[31:28]) and
//   serves UART control/receive/transmit registers plus cycle and retired
//   instruction counters. Read data is registered for the stage-3 writeback.
//
// Ports
//   clk_i            core clock
//   rst_i            synchronous active-high reset
//   addr_i           stage-2 effective address
//   ren_i / wen_i    stage-2 load / store
//   wdata_i          stage-2 store data
//   inst_valid_i     an instruction retires in stage 3 this cycle
//   rdata_o          registered read data (stage 3)
//   mmio_hit_o       registered: stage-3 load was an MMIO read
//   uart_rx_*        receive byte, valid in / ready out (ready is combinational)
//   uart_tx_*        transmit holding register, data/valid out, ready in
module mmio_responder #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        ren_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  input  logic        inst_valid_i,
  output logic [31:0] rdata_o,
  output logic        mmio_hit_o,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ready_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_ready_i
);

  localparam logic [7:0] OFF_UART_CTRL = 8'h00;
  localparam logic [7:0] OFF_UART_RX   = 8'h04;
  localparam logic [7:0] OFF_UART_TX   = 8'h08;
  localparam logic [7:0] OFF_CYCLE     = 8'h10;
  localparam logic [7:0] OFF_INSTRET   = 8'h14;
  localparam logic [7:0] OFF_CNT_CLR   = 8'h18;

  logic [31:0] rdata_q,   rdata_d;
  logic        hit_q,     hit_d;
  logic        tx_pend_q, tx_pend_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] cyc_q,     cyc_d;
  logic [31:0] inst_q,    inst_d;

  logic        hit;
  logic [7:0]  offset;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] rd_mux;

  assign hit    = (addr_i[31:28] == MMIO_BASE[31:28]);
  assign offset = addr_i[7:0];
  // A simultaneous store wins over the load, so the load is not served.
  assign rd_req = ren_i & ~wen_i & hit;
  assign wr_req = wen_i & hit;

  assign uart_rx_ready_o = ren_i & hit & (offset == OFF_UART_RX) & uart_rx_valid_i;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rd_mux = 32'h0;
    unique case (offset)
      OFF_UART_CTRL: rd_mux = {30'h0, uart_rx_valid_i, uart_tx_ready_i & ~tx_pend_q};
      OFF_UART_RX:   rd_mux = {24'h0, uart_rx_data_i};
      OFF_CYCLE:     rd_mux = cyc_q;   // value before this cycle's increment
      OFF_INSTRET:   rd_mux = inst_q;
      default:       rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d   = rd_req ? rd_mux : 32'h0;
    hit_d     = rd_req;

    tx_pend_d = tx_pend_q;
    tx_data_d = tx_data_q;
    // Handshake completes this edge; valid is low in the following cycle.
    if (tx_pend_q && uart_tx_ready_i) tx_pend_d = 1'b0;
    // Writes while a byte is pending are dropped silently.
    if (wr_req && (offset == OFF_UART_TX) && !tx_pend_q) begin
      tx_pend_d = 1'b1;
      tx_data_d = wdata_i[7:0];
    end

    if (wr_req && (offset == OFF_CNT_CLR)) begin
      // Clear overrides this cycle's increments.
      cyc_d  = 32'h0;
      inst_d = 32'h0;
    end else begin
      cyc_d  = cyc_q + 32'd1;
      inst_d = inst_q + {31'h0, inst_valid_i};
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst_i) begin
      rdata_q   <= 32'h0;
      hit_q     <= 1'b0;
      tx_pend_q <= 1'b0;
      tx_data_q <= 8'h0;
      cyc_q     <= 32'h0;
      inst_q    <= 32'h0;
    end else begin
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      tx_pend_q <= tx_pend_d;
      tx_data_q <= tx_data_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
    end
  end

  assign rdata_o         = rdata_q;
  assign mmio_hit_o      = hit_q;
  assign uart_tx_valid_o = tx_pend_q;
  assign uart_tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: a vector table for single-cycle
// register reads and decode, plus directed sequences for TX handshake,
// counter clear, counter wrap and reset during a pending transmit.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        ren, wen;
  logic [31:0] wdata;
  logic        inst_valid;
  logic [31:0] rdata;
  logic        mmio_hit;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .addr_i          (addr),
    .ren_i           (ren),
    .wen_i           (wen),
    .wdata_i         (wdata),
    .inst_valid_i    (inst_valid),
    .rdata_o         (rdata),
    .mmio_hit_o      (mmio_hit),
    .uart_rx_data_i  (rx_data),
    .uart_rx_valid_i (rx_valid),
    .uart_rx_ready_o (rx_ready),
    .uart_tx_data_o  (tx_data),
    .uart_tx_valid_o (tx_valid),
    .uart_tx_ready_i (tx_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic        exp_rx_ready;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    addr = 32'h0; ren = 1'b0; wen = 1'b0; wdata = 32'h0; inst_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a);
    idle();
    addr = a; ren = 1'b1;
    tick();
    idle();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    idle();
    addr = a; wen = 1'b1; wdata = d;
    tick();
    idle();
  endtask

  initial begin
    vecs[0] = '{"ctrl_tx_rdy",   32'h8000_0000, 1, 0, 8'h00, 0, 1, 0, 32'h1,  1};
    vecs[1] = '{"ctrl_rx_vld",   32'h8000_0000, 1, 0, 8'h00, 1, 0, 0, 32'h2,  1};
    vecs[2] = '{"rx_read",       32'h8000_0004, 1, 0, 8'h5A, 1, 0, 1, 32'h5A, 1};
    vecs[3] = '{"rx_read_novld", 32'h8000_0004, 1, 0, 8'h33, 0, 0, 0, 32'h33, 1};
    vecs[4] = '{"non_hit_load",  32'h4000_0004, 1, 0, 8'h77, 1, 0, 0, 32'h0,  0};
    vecs[5] = '{"unlisted_off",  32'h8000_000C, 1, 0, 8'h00, 0, 1, 0, 32'h0,  1};
    vecs[6] = '{"offset_decode", 32'h8123_4500, 1, 0, 8'h00, 1, 1, 0, 32'h3,  1};
    vecs[7] = '{"ren_and_wen",   32'h8000_0004, 1, 1, 8'h11, 0, 0, 0, 32'h0,  0};
    vecs[8] = '{"store_no_hit",  32'h8000_0000, 0, 1, 8'h00, 1, 1, 0, 32'h0,  0};
  end

  initial begin
    idle();
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;

    // Reset: outputs zero while rst is high.
    repeat (3) tick();
    check("rst_rdata",    rdata,    32'h0);
    check("rst_hit",      {31'h0, mmio_hit}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);

    // Ten idle cycles, then read the cycle counter twice back to back.
    rst = 1'b0;
    repeat (10) tick();
    idle(); addr = 32'h8000_0010; ren = 1'b1;
    tick();
    check("cyc_after_10", rdata, 32'd10);
    check("cyc_hit",      {31'h0, mmio_hit}, 32'h1);
    tick();
    check("cyc_b2b",      rdata, 32'd11);
    idle();

    // Table-driven register reads and decode.
    foreach (vecs[i]) begin
      idle();
      addr = vecs[i].addr; ren = vecs[i].ren; wen = vecs[i].wen;
      rx_data = vecs[i].rx_data; rx_valid = vecs[i].rx_valid; tx_ready = vecs[i].tx_ready;
      #1;
      check({vecs[i].name, "_rx_ready"}, {31'h0, rx_ready}, {31'h0, vecs[i].exp_rx_ready});
      tick();
      check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_hit"},   {31'h0, mmio_hit}, {31'h0, vecs[i].exp_hit});
    end
    idle(); rx_valid = 1'b0; tx_ready = 1'b0;
    #1;
    check("rx_ready_one_cycle", {31'h0, rx_ready}, 32'h0);
    check("no_tx_from_tbl", {31'h0, tx_valid}, 32'h0);

    // TX: store with transmitter stalled, byte held, second store dropped.
    store(32'h8000_0008, 32'h1234_5641);
    check("tx_valid_set", {31'h0, tx_valid}, 32'h1);
    check("tx_data_41",   {24'h0, tx_data},  32'h41);
    check("store_hit0",   {31'h0, mmio_hit}, 32'h0);
    tick(); tick();
    check("tx_valid_hold", {31'h0, tx_valid}, 32'h1);
    store(32'h8000_0008, 32'h0000_0042);
    check("tx_drop_2nd", {24'h0, tx_data}, 32'h41);
    load(32'h8000_0000);
    check("ctrl_pending", rdata, 32'h0);
    tx_ready = 1'b1;
    #1;
    check("tx_valid_pre_acc", {31'h0, tx_valid}, 32'h1);
    tick();
    check("tx_valid_fall", {31'h0, tx_valid}, 32'h0);
    check("tx_data_kept",  {24'h0, tx_data},  32'h41);
    load(32'h8000_0000);
    check("ctrl_idle_rdy", rdata, 32'h1);
    tx_ready = 1'b0;

    // Instruction counter: 7 retirements in 20 cycles, then clear.
    for (int i = 0; i < 20; i++) begin
      idle();
      inst_valid = (i % 3 == 0);
      tick();
    end
    load(32'h8000_0014);
    check("instret_7", rdata, 32'd7);
    idle(); addr = 32'h8000_0018; wen = 1'b1; inst_valid = 1'b1;
    tick();
    load(32'h8000_0014);
    check("instret_clr", rdata, 32'd0);
    load(32'h8000_0010);
    check("cyc_clr_plus1", rdata, 32'd1);

    // Cycle counter wrap.
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    load(32'h8000_0010);
    check("cyc_max", rdata, 32'hFFFF_FFFF);
    load(32'h8000_0010);
    check("cyc_wrap", rdata, 32'h0);
    load(32'h4000_0000);
    check("nohit_rdata", rdata, 32'h0);
    check("nohit_hit",   {31'h0, mmio_hit}, 32'h0);

    // Reset with a byte pending.
    store(32'h8000_0008, 32'h0000_00C3);
    check("tx_pend_pre_rst", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1; inst_valid = 1'b1;
    tick();
    check("rst_tx_drop", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data_clr", {24'h0, tx_data}, 32'h0);
    rst = 1'b0;
    load(32'h8000_0010);
    check("rst_cyc_zero", rdata, 32'h0);
    load(32'h8000_0014);
    check("rst_inst_zero", rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
